// File: rtl/game_pkg.sv
// Shared types and encodings for the piano-block play-flow controller.
package game_pkg;

    typedef enum logic [1:0] {
        TITLE,
        COUNTDOWN,
        PLAY,
        OVER
    } state_e;

    localparam logic [2:0] ST_TITLE = 3'b001;
    localparam logic [2:0] ST_PLAY  = 3'b010;
    localparam logic [2:0] ST_OVER  = 3'b100;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/beat_prescaler.sv
// Free-running tick divider with a loadable period and synchronous clear.
module beat_prescaler #(
    parameter int unsigned RESET_PERIOD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] period_in,
    input  logic        clr,
    output logic        tick
);

    logic [31:0] period_q;
    logic [31:0] cnt_q;

    assign tick = (cnt_q == period_q - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= 32'(RESET_PERIOD);
            cnt_q    <= 32'd0;
        end else if (load) begin
            period_q <= period_in;
            cnt_q    <= 32'd0;
        end else if (clr || tick) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Play-flow controller: title, countdown, play and game-over states, driving the note
// address and a single-clock beat strobe for all downstream consumers.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned EASY_HZ  = 2,
    parameter int unsigned HARD_HZ  = 4,
    parameter int unsigned SONG_LEN = 128,
    parameter int unsigned LOOPS    = 2,
    parameter int unsigned CD_BEATS = 3,
    localparam int unsigned AW      = $clog2(SONG_LEN),
    localparam int unsigned CW      = $clog2(CD_BEATS + 1),
    localparam int unsigned LW      = $clog2(LOOPS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    choice,
    input  logic          level,
    input  logic          start,
    output logic [2:0]    status,
    output logic [AW-1:0] addr,
    output logic          beat,
    output logic [CW-1:0] countdown,
    output logic [LW-1:0] loop_cnt,
    output logic          song_done,
    output logic [2:0]    song_sel
);

    localparam logic [31:0]   P_EASY    = 32'(CLK_HZ / EASY_HZ);
    localparam logic [31:0]   P_HARD    = 32'(CLK_HZ / HARD_HZ);
    localparam logic [AW-1:0] LAST_ADDR = AW'(SONG_LEN - 1);

    state_e state_q;
    logic   tick;
    logic   go, abort, cd_done, last_beat, restart, pre_clr;

    always_comb begin
        go        = 1'b0;
        abort     = 1'b0;
        cd_done   = 1'b0;
        last_beat = 1'b0;
        restart   = 1'b0;
        unique case (state_q)
            TITLE:     go = start && is_onehot3(choice);
            COUNTDOWN: begin
                abort   = (choice != song_sel);
                cd_done = !abort && tick && (countdown == CW'(1));
            end
            PLAY: begin
                abort     = (choice != song_sel);
                last_beat = !abort && tick && (addr == LAST_ADDR) &&
                            (loop_cnt == LW'(LOOPS - 1));
            end
            OVER:      restart = start;
            default:   ;
        endcase
        // Every state entry restarts the period; entry to COUNTDOWN does so via load.
        pre_clr = abort || cd_done || last_beat || restart;
    end

    beat_prescaler #(
        .RESET_PERIOD(P_EASY)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (go),
        .period_in(level ? P_HARD : P_EASY),
        .clr      (pre_clr),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TITLE;
            status    <= ST_TITLE;
            addr      <= '0;
            beat      <= 1'b0;
            countdown <= '0;
            loop_cnt  <= '0;
            song_done <= 1'b0;
            song_sel  <= 3'b001;
        end else begin
            beat      <= 1'b0;
            song_done <= 1'b0;
            unique case (state_q)
                TITLE: begin
                    if (go) begin
                        state_q   <= COUNTDOWN;
                        status    <= ST_PLAY;
                        song_sel  <= choice;
                        countdown <= CW'(CD_BEATS);
                    end
                end
                COUNTDOWN: begin
                    if (abort) begin
                        state_q   <= TITLE;
                        status    <= ST_TITLE;
                        addr      <= '0;
                        countdown <= '0;
                        loop_cnt  <= '0;
                    end else if (tick) begin
                        if (cd_done) begin
                            state_q   <= PLAY;
                            countdown <= '0;
                            addr      <= '0;
                            loop_cnt  <= '0;
                        end else begin
                            countdown <= countdown - CW'(1);
                        end
                    end
                end
                PLAY: begin
                    if (abort) begin
                        state_q   <= TITLE;
                        status    <= ST_TITLE;
                        addr      <= '0;
                        countdown <= '0;
                        loop_cnt  <= '0;
                    end else if (tick) begin
                        beat <= 1'b1;
                        if (addr == LAST_ADDR) begin
                            addr <= '0;
                            if (last_beat) begin
                                state_q   <= OVER;
                                status    <= ST_OVER;
                                song_done <= 1'b1;
                                loop_cnt  <= LW'(LOOPS);
                            end else begin
                                loop_cnt <= loop_cnt + LW'(1);
                            end
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end
                end
                OVER: begin
                    if (restart) begin
                        state_q  <= TITLE;
                        status   <= ST_TITLE;
                        loop_cnt <= '0;
                    end
                end
                default: begin
                    state_q <= TITLE;
                    status  <= ST_TITLE;
                end
            endcase
        end
    end

endmodule
